// File: rtl/prog_pkg.sv
// Shared definitions for the render-program loader.
// Command codes, sync marker and loader FSM states.
package prog_pkg;

    localparam logic [7:0] SYNC_BYTE   = 8'hA5;
    localparam logic [7:0] CMD_LOAD    = 8'h01;
    localparam logic [7:0] CMD_SYM_ON  = 8'h02;
    localparam logic [7:0] CMD_SYM_OFF = 8'h03;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_PAYLD,
        ST_CSUM,
        ST_CHECK
    } loader_state_t;

endpackage

// File: rtl/prog_timeout.sv
// Inter-byte watchdog for the packet loader.
// Counts idle cycles while armed; expire flags the last allowed cycle.
module prog_timeout #(
    parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
    input  logic clk_pix,
    input  logic rst_pix,
    input  logic en,
    input  logic xfer,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT_CYC);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            cnt <= '0;
        end else if (!en || xfer) begin
            cnt <= '0;
        end else if (cnt != LAST) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expire = en && !xfer && (cnt == LAST);

endmodule

// File: rtl/prog_loader.sv
// Byte-stream packet loader feeding the render datapath.
// Validated packets sit in a shadow register until the next frame start.
module prog_loader #(
    parameter int unsigned PROG_PAYLD_PKT_BITS = 48,
    parameter logic [7:0]  SYNC_BYTE = prog_pkg::SYNC_BYTE,
    parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
    input  logic                           clk_pix,
    input  logic                           rst_pix,
    input  logic [7:0]                     rx_data,
    input  logic                           rx_valid,
    output logic                           rx_ready,
    input  logic                           frame_start,
    output logic [PROG_PAYLD_PKT_BITS-1:0] prog_buffer,
    output logic                           is_sym_mode,
    output logic                           pkt_err,
    output logic                           pkt_ok,
    output logic                           busy
);

    import prog_pkg::*;

    localparam int NB = PROG_PAYLD_PKT_BITS / 8;
    localparam int IW = $clog2(NB + 1);
    localparam int W  = PROG_PAYLD_PKT_BITS;

    loader_state_t state;
    logic [IW-1:0] idx;
    logic [7:0]    acc;
    logic [7:0]    csum_rx;
    logic [W-1:0]  stage_buf;
    logic          stage_load;
    logic          stage_mode;
    logic [W-1:0]  shadow_buf;
    logic          shadow_mode;
    logic          pending;
    logic          xfer;
    logic          expire;
    logic          armed;

    assign xfer  = rx_valid && rx_ready;
    assign armed = (state == ST_CMD) || (state == ST_PAYLD) ||
                   (state == ST_CSUM);
    assign busy  = (state != ST_IDLE);

    prog_timeout #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timeout (
        .clk_pix(clk_pix),
        .rst_pix(rst_pix),
        .en     (armed),
        .xfer   (xfer),
        .expire (expire)
    );

    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            state       <= ST_IDLE;
            idx         <= '0;
            acc         <= '0;
            csum_rx     <= '0;
            stage_buf   <= '0;
            stage_load  <= 1'b0;
            stage_mode  <= 1'b0;
            shadow_buf  <= '0;
            shadow_mode <= 1'b0;
            pending     <= 1'b0;
            prog_buffer <= '0;
            is_sym_mode <= 1'b0;
            rx_ready    <= 1'b0;
            pkt_err     <= 1'b0;
            pkt_ok      <= 1'b0;
        end else begin
            pkt_err <= 1'b0;
            pkt_ok  <= 1'b0;

            // Commit sees pending from before this edge; CHECK may re-arm it below.
            if (frame_start && pending) begin
                prog_buffer <= shadow_buf;
                is_sym_mode <= shadow_mode;
                pending     <= 1'b0;
            end

            unique case (state)
                ST_IDLE: begin
                    rx_ready <= 1'b1;
                    if (xfer && rx_data == SYNC_BYTE)
                        state <= ST_CMD;
                end
                ST_CMD: begin
                    if (expire) begin
                        pkt_err <= 1'b1;
                        state   <= ST_IDLE;
                    end else if (xfer) begin
                        acc <= rx_data;
                        unique case (rx_data)
                            CMD_LOAD: begin
                                idx        <= '0;
                                stage_load <= 1'b1;
                                stage_mode <= 1'b1;
                                state      <= ST_PAYLD;
                            end
                            CMD_SYM_ON: begin
                                stage_load <= 1'b0;
                                stage_mode <= 1'b1;
                                state      <= ST_CSUM;
                            end
                            CMD_SYM_OFF: begin
                                stage_load <= 1'b0;
                                stage_mode <= 1'b0;
                                state      <= ST_CSUM;
                            end
                            default: begin
                                pkt_err <= 1'b1;
                                state   <= ST_IDLE;
                            end
                        endcase
                    end
                end
                ST_PAYLD: begin
                    if (expire) begin
                        pkt_err <= 1'b1;
                        state   <= ST_IDLE;
                    end else if (xfer) begin
                        for (int i = 0; i < NB; i++)
                            if (idx == IW'(i))
                                stage_buf[8*i +: 8] <= rx_data;
                        acc <= acc ^ rx_data;
                        idx <= idx + 1'b1;
                        if (idx == IW'(NB - 1))
                            state <= ST_CSUM;
                    end
                end
                ST_CSUM: begin
                    if (expire) begin
                        pkt_err <= 1'b1;
                        state   <= ST_IDLE;
                    end else if (xfer) begin
                        csum_rx  <= rx_data;
                        rx_ready <= 1'b0;
                        state    <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    rx_ready <= 1'b1;
                    state    <= ST_IDLE;
                    if (csum_rx == acc) begin
                        if (stage_load)
                            shadow_buf <= stage_buf;
                        shadow_mode <= stage_mode;
                        pending     <= 1'b1;
                        pkt_ok      <= 1'b1;
                    end else begin
                        pkt_err <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
